// File: rtl/p16_pkg.sv
// Shared constants and stage payload types for the binary32 -> posit<16,1> converter.
package p16_pkg;

    localparam int          N         = 16;
    localparam int          ES        = 1;
    localparam int          BIAS      = 127;
    localparam logic [14:0] MAXPOS    = 15'h7FFF;
    localparam logic [14:0] MINPOS    = 15'h0001;
    localparam logic [15:0] NAR       = 16'h8000;
    localparam int          SCALE_MAX = 28;
    localparam int          SCALE_MIN = -28;

    typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_TINY, CLS_NAR} f32_cls_t;

    typedef struct packed {
        logic              sign;
        f32_cls_t          cls;
        logic signed [8:0] scale;
        logic [22:0]       man;
    } s1_payload_t;

    typedef struct packed {
        logic        sign;
        f32_cls_t    cls;
        logic [14:0] mag;
        logic        guard;
        logic        sticky;
        logic        sat;
    } s2_payload_t;

endpackage

// File: rtl/p16_regime_pack.sv
// Combinational packer: regime, exponent and fraction into 15 posit magnitude bits
// plus guard and sticky. Expects a scale already limited to the representable range.
module p16_regime_pack #(
    parameter int ES = 1
) (
    input  logic signed [8:0] i_scale,
    input  logic [22:0]       i_man,
    output logic [14:0]       o_mag,
    output logic              o_guard,
    output logic              o_sticky
);

    localparam int FW = 48;

    logic signed [8:0]    w_k;
    logic [8:0]           w_run;
    logic signed [FW-1:0] w_base;
    logic signed [FW-1:0] w_field;

    always_comb begin
        w_k    = i_scale >>> ES;
        // An arithmetic shift of "10.." by k yields k+1 ones then 0; for k<0, shifting
        // "01.." by ~k (= -k-1) yields -k zeros then 1.
        w_run  = w_k[8] ? ~w_k : w_k;
        w_base = {(w_k[8] ? 2'b01 : 2'b10), i_scale[ES-1:0], i_man, {(FW-25-ES){1'b0}}};
        w_field = w_base >>> w_run;
        o_mag    = w_field[FW-1 -: 15];
        o_guard  = w_field[FW-16];
        o_sticky = |w_field[FW-17:0];
    end

endmodule

// File: rtl/f32_to_p16_pipe.sv
// Streaming binary32 -> posit<16,1> converter: unpack, encode, round, with
// valid/ready backpressure through all three stages.
module f32_to_p16_pipe #(
    parameter int N  = 16,
    parameter int ES = 1,
    parameter int FN = 32,
    parameter int FE = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [FN-1:0] float_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  posit_out,
    output logic          out_sat
);

    import p16_pkg::*;

    logic             r_v1, r_v2, r_v3;
    s1_payload_t      r_s1, w_s1;
    s2_payload_t      r_s2, w_s2;
    logic [N-1:0]     r_posit;
    logic             r_sat;
    logic             w_rdy2, w_rdy3;
    logic [FE-1:0]    w_exp;
    logic [FN-FE-2:0] w_man;
    logic [14:0]      w_pk_mag;
    logic             w_pk_guard, w_pk_sticky;
    logic             w_inc;
    logic [15:0]      w_sum;
    logic [14:0]      w_mag3;
    logic [N-1:0]     w_posit3;
    logic             w_sat3;

    assign w_rdy3    = ~r_v3 | out_ready;
    assign w_rdy2    = ~r_v2 | w_rdy3;
    assign in_ready  = ~r_v1 | w_rdy2;
    assign out_valid = r_v3;
    assign posit_out = r_posit;
    assign out_sat   = r_sat;

    always_comb begin
        w_exp       = float_in[FN-2 -: FE];
        w_man       = float_in[FN-FE-2:0];
        w_s1.sign   = float_in[FN-1];
        w_s1.man    = w_man;
        w_s1.scale  = 9'($signed({1'b0, w_exp}) - BIAS);
        if (w_exp == '0) begin
            w_s1.cls = (w_man == '0) ? CLS_ZERO : CLS_TINY;
        end else if (&w_exp) begin
            w_s1.cls = CLS_NAR;
        end else begin
            w_s1.cls = CLS_NORM;
        end
    end

    p16_regime_pack #(
        .ES(ES)
    ) u_pack (
        .i_scale (r_s1.scale),
        .i_man   (r_s1.man),
        .o_mag   (w_pk_mag),
        .o_guard (w_pk_guard),
        .o_sticky(w_pk_sticky)
    );

    always_comb begin
        w_s2.sign   = r_s1.sign;
        w_s2.cls    = r_s1.cls;
        w_s2.mag    = w_pk_mag;
        w_s2.guard  = w_pk_guard;
        w_s2.sticky = w_pk_sticky;
        w_s2.sat    = 1'b0;
        if (r_s1.cls == CLS_TINY || $signed(r_s1.scale) < SCALE_MIN) begin
            w_s2.mag    = MINPOS;
            w_s2.guard  = 1'b0;
            w_s2.sticky = 1'b0;
            w_s2.sat    = 1'b1;
        end else if ($signed(r_s1.scale) > SCALE_MAX) begin
            w_s2.mag    = MAXPOS;
            w_s2.guard  = 1'b0;
            w_s2.sticky = 1'b0;
            w_s2.sat    = 1'b1;
        end
    end

    always_comb begin
        w_inc  = r_s2.guard & (r_s2.sticky | r_s2.mag[0]);
        w_sum  = {1'b0, r_s2.mag} + {15'd0, w_inc};
        w_mag3 = w_sum[14:0];
        w_sat3 = r_s2.sat;
        if (w_sum > {1'b0, MAXPOS}) begin
            w_mag3 = MAXPOS;
            w_sat3 = 1'b1;
        end else if (w_sum == '0) begin
            w_mag3 = MINPOS;
            w_sat3 = 1'b1;
        end
        w_posit3 = r_s2.sign ? (16'h0000 - {1'b0, w_mag3}) : {1'b0, w_mag3};
        case (r_s2.cls)
            CLS_ZERO: begin
                w_posit3 = '0;
                w_sat3   = 1'b0;
            end
            CLS_NAR: begin
                w_posit3 = NAR;
                w_sat3   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_posit <= '0;
            r_sat   <= 1'b0;
        end else begin
            if (in_ready) begin
                r_v1 <= in_valid;
                if (in_valid) r_s1 <= w_s1;
            end
            if (w_rdy2) begin
                r_v2 <= r_v1;
                if (r_v1) r_s2 <= w_s2;
            end
            // Output payload only changes on a real transfer, so it holds under backpressure.
            if (w_rdy3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_posit <= w_posit3;
                    r_sat   <= w_sat3;
                end
            end
        end
    end

endmodule
